// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_LAST = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int RamBus = 8;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [1:0]  last;   // index of the final byte (n-1)
    logic [31:0] wdata;
  } req_t;

  // Size code to last byte index; the reserved code behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Byte-insert register: writes an 8-bit value into lane k of a 32-bit word.
// Clearing before a transfer gives zero-extension of short loads for free.
module byte_assembler
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [1:0]        lane_i,
  input  logic [RamBus-1:0] byte_i,
  output logic [31:0]       word_o
);

  logic [31:0] word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        word_q <= '0;
      end else if (load_i) begin
        word_q[{lane_i, 3'b000} +: RamBus] <= byte_i;
      end
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM requests onto an 8-bit RAM port, splitting and
// assembling little-endian words one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  output logic              if_stall_req_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              mem_stall_req_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [RamBus-1:0] ram_dout_o,
  input  logic [RamBus-1:0] ram_din_i
);

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [RamBus-1:0] ram_dout_q, ram_dout_d;

  req_t              acc_req;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_vld;
  logic [1:0]        nxt_k;

  logic              asm_clr, asm_load;
  logic [1:0]        asm_lane;
  logic [31:0]       asm_word;

  logic              in_done;

  // MEM has priority; an accepted request always runs to completion.
  always_comb begin
    acc_vld  = mem_req_i | if_req_i;
    acc_req  = '0;
    acc_addr = if_addr_i;
    if (mem_req_i) begin
      acc_req.port  = PORT_MEM;
      acc_req.we    = mem_we_i;
      acc_req.last  = last_idx(mem_size_i);
      acc_req.wdata = mem_wdata_i;
      acc_addr      = mem_addr_i;
    end else begin
      acc_req.port  = PORT_IF;
      acc_req.we    = 1'b0;
      acc_req.last  = 2'd3;
      acc_req.wdata = '0;
    end
  end

  assign nxt_k = k_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    base_d     = base_q;
    req_d      = req_q;
    ram_addr_d = ram_addr_q;
    ram_wr_d   = 1'b0;
    ram_dout_d = ram_dout_q;
    asm_clr    = 1'b0;
    asm_load   = 1'b0;
    asm_lane   = k_q;

    case (state_q)
      IDLE: begin
        if (acc_vld) begin
          req_d      = acc_req;
          base_d     = acc_addr;
          k_d        = 2'd0;
          ram_addr_d = acc_addr;
          asm_clr    = 1'b1;
          if (acc_req.we) begin
            state_d    = WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = acc_req.wdata[RamBus-1:0];
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        // Data for the address presented last cycle is on ram_din_i now.
        if (k_q != 2'd0) begin
          asm_load = 1'b1;
          asm_lane = k_q - 2'd1;
        end
        if (k_q == req_q.last) begin
          state_d = RD_LAST;
        end else begin
          k_d        = nxt_k;
          ram_addr_d = base_q + ADDR_W'(nxt_k);
        end
      end
      RD_LAST: begin
        asm_load = 1'b1;
        asm_lane = k_q;
        state_d  = DONE;
      end
      WR: begin
        if (k_q == req_q.last) begin
          state_d = DONE;
        end else begin
          k_d        = nxt_k;
          ram_addr_d = base_q + ADDR_W'(nxt_k);
          ram_wr_d   = 1'b1;
          ram_dout_d = req_q.wdata[{nxt_k, 3'b000} +: RamBus];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      base_q     <= '0;
      req_q      <= '0;
      ram_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      req_q      <= req_d;
      ram_addr_q <= ram_addr_d;
      ram_wr_q   <= ram_wr_d;
      ram_dout_q <= ram_dout_d;
    end
  end

  byte_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .en_i   (rdy),
    .clr_i  (asm_clr),
    .load_i (asm_load),
    .lane_i (asm_lane),
    .byte_i (ram_din_i),
    .word_o (asm_word)
  );

  // A fetch whose requester moved on (branch redirect) completes silently.
  assign in_done    = (state_q == DONE) && rdy;
  assign if_done_o  = in_done && (req_q.port == PORT_IF) && if_req_i && (if_addr_i == base_q);
  assign mem_done_o = in_done && (req_q.port == PORT_MEM);

  assign if_data_o  = if_done_o  ? asm_word : '0;
  assign mem_rdata_o = mem_done_o ? asm_word : '0;

  assign if_stall_req_o  = if_req_i  & ~if_done_o;
  assign mem_stall_req_o = mem_req_i & ~mem_done_o;

  assign ram_addr_o = ram_addr_q;
  assign ram_wr_o   = ram_wr_q & rdy;
  assign ram_dout_o = ram_dout_q;

endmodule
